// File: rtl/conv_window_gen.sv
// -----------------------------------------------------------------------------
// conv_window_gen
//
// Walks a flat, row-major N x N feature map and presents every 5x5 valid
// convolution window (stride 1, no padding) to the downstream MAC stage over
// a valid/ready handshake. Windows come out in raster order of the output map
// (column fastest). The pass ends with a one-cycle done pulse.
//
// Ports:
//   clk        : single clock, rising edge
//   reset      : synchronous, active-high; returns to IDLE and clears outputs
//   start      : begin a pass, only looked at in IDLE
//   size       : image side N, captured on an accepted start
//   img        : loaded feature map, img[y*N + x], held stable while busy
//   window     : current window, window[r*KERNEL + c] = img[(row+r)*N + col+c]
//   win_valid  : window/row/col are valid
//   win_ready  : consumer accepts when win_valid & win_ready
//   row, col   : output-map coordinates of the current window
//   busy       : high whenever the FSM is outside IDLE
//   done       : one-cycle pulse at the end of a pass
//   size_err   : raised together with done when N < KERNEL or N > 32,
//                cleared on the next accepted start
// -----------------------------------------------------------------------------
module conv_window_gen #(
    parameter int DATA_SIZE      = 16,
    parameter int BUF_DEPTH      = 1024,
    parameter int KERNEL         = 5,
    parameter int IMG_SIZE_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [IMG_SIZE_WIDTH-1:0]   size,
    input  logic signed [DATA_SIZE-1:0] img    [BUF_DEPTH],
    output logic signed [DATA_SIZE-1:0] window [KERNEL*KERNEL],
    output logic                        win_valid,
    input  logic                        win_ready,
    output logic [7:0]                  row,
    output logic [7:0]                  col,
    output logic                        busy,
    output logic                        done,
    output logic                        size_err
);

    localparam int WIN_LEN = KERNEL * KERNEL;
    localparam int MAX_N   = 32;
    localparam int N_W     = $clog2(MAX_N + 1);
    localparam int IDX_W   = $clog2(BUF_DEPTH);
    // One bit wider than the buffer index so an out-of-range address is
    // visible instead of silently wrapping; never narrower than 11 bits.
    localparam int ADDR_W  = (IDX_W + 1 > 11) ? IDX_W + 1 : 11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_EMIT = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [N_W-1:0] n_q, n_d;
    logic [7:0]     row_q, row_d;
    logic [7:0]     col_q, col_d;
    logic           size_err_q, size_err_d;

    logic signed [DATA_SIZE-1:0] window_q [WIN_LEN];

    logic        size_ok;
    logic [7:0]  last_idx;
    logic        last_win;
    logic        handshake;

    logic [ADDR_W-1:0] row_ext;
    logic [ADDR_W-1:0] col_ext;
    logic [ADDR_W-1:0] n_ext;

    // -------------------------------------------------------------------------
    // Shared decode
    // -------------------------------------------------------------------------
    assign size_ok = (size >= IMG_SIZE_WIDTH'(KERNEL)) &&
                     (size <= IMG_SIZE_WIDTH'(MAX_N));

    // Highest valid row/col index of the output map: M-1 = N-KERNEL.
    assign last_idx  = 8'(n_q) - 8'(KERNEL);
    assign last_win  = (row_q == last_idx) && (col_q == last_idx);
    assign handshake = (state_q == S_EMIT) && win_ready;

    assign row_ext = ADDR_W'(row_q);
    assign col_ext = ADDR_W'(col_q);
    assign n_ext   = ADDR_W'(n_q);

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    // A bad size still goes through FIN so the caller always
                    // sees a done pulse, just with size_err raised.
                    state_d = size_ok ? S_LOAD : S_FIN;
                end
            end
            S_LOAD: begin
                state_d = S_EMIT;
            end
            S_EMIT: begin
                if (win_ready) begin
                    state_d = last_win ? S_FIN : S_LOAD;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs decoded from the current state
    // -------------------------------------------------------------------------
    always_comb begin
        busy      = (state_q != S_IDLE);
        win_valid = (state_q == S_EMIT);
        done      = (state_q == S_FIN);
    end

    // -------------------------------------------------------------------------
    // Pass bookkeeping: image size, window position, error flag
    // -------------------------------------------------------------------------
    always_comb begin
        n_d        = n_q;
        row_d      = row_q;
        col_d      = col_q;
        size_err_d = size_err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    size_err_d = !size_ok;
                    row_d      = '0;
                    col_d      = '0;
                    if (size_ok) begin
                        n_d = size[N_W-1:0];
                    end
                end
            end
            S_EMIT: begin
                if (handshake) begin
                    if (col_q < last_idx) begin
                        col_d = col_q + 8'd1;
                    end else begin
                        col_d = '0;
                        row_d = row_q + 8'd1;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            n_q        <= '0;
            row_q      <= '0;
            col_q      <= '0;
            size_err_q <= 1'b0;
        end else begin
            n_q        <= n_d;
            row_q      <= row_d;
            col_q      <= col_d;
            size_err_q <= size_err_d;
        end
    end

    // -------------------------------------------------------------------------
    // Window gather: one address generator and register per tap. The whole
    // window is captured in the single LOAD cycle and then held untouched
    // through EMIT, which keeps it stable under backpressure.
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < WIN_LEN; gi++) begin : g_tap
            localparam int TAP_R = gi / KERNEL;
            localparam int TAP_C = gi % KERNEL;

            logic [ADDR_W-1:0]           addr;
            logic signed [DATA_SIZE-1:0] tap_d;

            assign addr = (row_ext + ADDR_W'(TAP_R)) * n_ext
                        + col_ext + ADDR_W'(TAP_C);

            // Cannot go out of range for an accepted size; the guard only
            // keeps a smaller BUF_DEPTH build from aliasing.
            assign tap_d = (addr < ADDR_W'(BUF_DEPTH)) ? img[addr[IDX_W-1:0]]
                                                       : '0;

            always_ff @(posedge clk) begin
                if (reset) begin
                    window_q[gi] <= '0;
                end else if (state_q == S_LOAD) begin
                    window_q[gi] <= tap_d;
                end
            end

            assign window[gi] = window_q[gi];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Output assignments
    // -------------------------------------------------------------------------
    assign row      = row_q;
    assign col      = col_q;
    assign size_err = size_err_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// -----------------------------------------------------------------------------
// tb_conv_window_gen
//
// Drives conv_window_gen with a sequence of passes and compares every
// presented window against windows computed directly from the image array
// (window k of an M x M map sits at row k/M, col k%M).
// -----------------------------------------------------------------------------
module tb_conv_window_gen;

    logic               clk;
    logic               reset;
    logic               start;
    logic [15:0]        size;
    logic signed [15:0] img    [1024];
    logic signed [15:0] window [25];
    logic               win_valid;
    logic               win_ready;
    logic [7:0]         row;
    logic [7:0]         col;
    logic               busy;
    logic               done;
    logic               size_err;

    int img_val [1024];
    int n_checks = 0;
    int n_pass   = 0;

    conv_window_gen #(
        .DATA_SIZE      (16),
        .BUF_DEPTH      (1024),
        .KERNEL         (5),
        .IMG_SIZE_WIDTH (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .size      (size),
        .img       (img),
        .window    (window),
        .win_valid (win_valid),
        .win_ready (win_ready),
        .row       (row),
        .col       (col),
        .busy      (busy),
        .done      (done),
        .size_err  (size_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input longint observed, input longint expected);
        n_checks++;
        if (observed == expected) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    // mode 0: img[i] = i, mode 1: img[i] = i - 512, otherwise random signed
    task automatic fill_img(input int mode);
        for (int i = 0; i < 1024; i++) begin
            if (mode == 0) begin
                img_val[i] = i;
            end else if (mode == 1) begin
                img_val[i] = i - 512;
            end else begin
                img_val[i] = int'($signed(16'($urandom)));
            end
            img[i] = 16'(img_val[i]);
        end
    endtask

    // One pass of size n. With reset_after >= 0 the pass is cut by a reset
    // right after that many handshakes. poke_start pulses start mid-pass.
    task automatic run_pass(input int n, input bit rnd_ready, input int reset_after,
                            input bit poke_start);
        bit ok_size;
        bit finished;
        bit prev_valid;
        bit prev_hs;
        bit hs;
        bit do_reset;
        int m;
        int exp_cnt;
        int lat;
        int budget;
        int k;
        int cyc;
        int j;
        int r0;
        int c0;
        int ew;

        ok_size    = (n >= 5) && (n <= 32);
        m          = ok_size ? n - 4 : 0;
        exp_cnt    = m * m;
        lat        = ok_size ? 2 * exp_cnt + 1 : 1;
        budget     = 8 * exp_cnt + 16;
        k          = 0;
        finished   = 1'b0;
        prev_valid = 1'b0;
        prev_hs    = 1'b0;
        do_reset   = 1'b0;

        @(negedge clk);
        size      = 16'(n);
        start     = 1'b1;
        win_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        check("busy_after_start", busy, 1);
        check("size_err_after_start", size_err, ok_size ? 0 : 1);

        while (cyc < budget && !finished) begin
            win_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            start     = poke_start && (cyc == 5 || cyc == 20);
            if (start) size = 16'd4;
            if (prev_valid && !prev_hs) check("valid_hold", win_valid, 1);
            hs = 1'b0;
            if (done) begin
                finished = 1'b1;
                check("done_excl_valid", win_valid, 0);
                check("win_count", k, exp_cnt);
                check("size_err_at_done", size_err, ok_size ? 0 : 1);
                if (!rnd_ready) check("done_latency", cyc, lat);
            end else if (win_valid) begin
                if (k >= exp_cnt) begin
                    check("extra_win", win_valid, 0);
                end else begin
                    r0 = k / m;
                    c0 = k % m;
                    check($sformatf("win%0d_row", k), row, r0);
                    check($sformatf("win%0d_col", k), col, c0);
                    j = 0;
                    for (int q = 0; q < 25; q++) begin
                        if (int'(window[q]) != img_val[(r0 + q / 5) * n + c0 + q % 5]) begin
                            j = q;
                            break;
                        end
                    end
                    ew = img_val[(r0 + j / 5) * n + c0 + j % 5];
                    check($sformatf("win%0d_w%0d", k, j), window[j], ew);
                    if (n == 8 && r0 == 2 && c0 == 3) begin
                        check("n8_r2c3_w0", window[0], 19 - 512);
                        check("n8_r2c3_w24", window[24], 55 - 512);
                    end
                    if (n == 32 && k == exp_cnt - 1) begin
                        check("n32_last_w24", window[24], img_val[1023]);
                    end
                end
                hs = win_ready;
                if (hs) begin
                    $display("N=%0d win %0d (%0d,%0d) w0=%0d w24=%0d",
                             n, k, row, col, window[0], window[24]);
                    k++;
                    if (reset_after >= 0 && k == reset_after) do_reset = 1'b1;
                end
            end
            prev_valid = win_valid;
            prev_hs    = hs;
            if (!finished) begin
                @(negedge clk);
                cyc++;
                if (do_reset) begin
                    start = 1'b0;
                    reset = 1'b1;
                    repeat (2) @(negedge clk);
                    check("midrst_valid", win_valid, 0);
                    check("midrst_busy", busy, 0);
                    check("midrst_row", row, 0);
                    check("midrst_col", col, 0);
                    check("midrst_done", done, 0);
                    reset = 1'b0;
                    $display("N=%0d reset after %0d handshakes", n, k);
                    return;
                end
            end
        end
        start = 1'b0;

        if (!finished) begin
            check("timeout_done", done, 1);
        end else begin
            $display("N=%0d pass end after %0d cycles, %0d windows, size_err=%0d",
                     n, cyc, k, size_err);
            @(negedge clk);
            check("done_pulse", done, 0);
            check("idle_busy", busy, 0);
        end
    endtask

    initial begin
        int j;
        reset     = 1'b1;
        start     = 1'b0;
        size      = '0;
        win_ready = 1'b0;
        fill_img(0);
        repeat (2) @(negedge clk);
        check("rst_valid", win_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_size_err", size_err, 0);
        check("rst_row", row, 0);
        check("rst_col", col, 0);
        j = 0;
        for (int q = 0; q < 25; q++) begin
            if (window[q] != 16'sd0) begin
                j = q;
                break;
            end
        end
        check("rst_window", window[j], 0);
        reset = 1'b0;

        fill_img(0);
        run_pass(5, 1'b0, -1, 1'b0);
        fill_img(1);
        run_pass(8, 1'b1, -1, 1'b0);
        fill_img(2);
        run_pass(32, 1'b0, -1, 1'b0);
        run_pass(4, 1'b0, -1, 1'b0);
        run_pass(33, 1'b0, -1, 1'b0);
        fill_img(2);
        run_pass(6, 1'b1, -1, 1'b0);
        fill_img(2);
        run_pass(10, 1'b0, 7, 1'b0);
        run_pass(10, 1'b1, -1, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
